// File: rtl/c_unary_stream_chk_pkg.sv
// Shared types for the streaming unary-code checker: FSM states, result record, length ceiling.
package c_pkg;

  typedef enum logic [1:0] {S_FIRST, S_LEAD, S_TRAIL, S_BAD} c_unary_state_t;

  localparam int C_CNT_W = 12;
  localparam logic [C_CNT_W-1:0] C_LEN_MAX = '1;

  typedef struct packed {
    logic               is_unary;
    logic [C_CNT_W-1:0] count;
    logic [C_CNT_W-1:0] len;
  } c_unary_result_t;

endpackage

// File: rtl/c_unary_stream_chk_if.sv
// Beat ingress + result egress bundle; stat counters appear only with C_UNARY_STREAM_STATS_EN.
interface c_unary_stream_chk_if #(
  parameter int P_W     = 8,
  parameter int P_CNT_W = 12
);
  logic               i_vld;
  logic               o_rdy;
  logic [P_W-1:0]     i_x;
  logic               i_last;
  logic               i_cfg_compliment;
  logic               o_res_vld;
  logic               i_res_rdy;
  logic               o_res_is_unary;
  logic [P_CNT_W-1:0] o_res_count;
  logic [P_CNT_W-1:0] o_res_len;
`ifdef C_UNARY_STREAM_STATS_EN
  logic [31:0]        o_stat_ok;
  logic [31:0]        o_stat_bad;

  modport slave (
    input  i_vld, i_x, i_last, i_cfg_compliment, i_res_rdy,
    output o_rdy, o_res_vld, o_res_is_unary, o_res_count, o_res_len, o_stat_ok, o_stat_bad
  );
  modport master (
    output i_vld, i_x, i_last, i_cfg_compliment, i_res_rdy,
    input  o_rdy, o_res_vld, o_res_is_unary, o_res_count, o_res_len, o_stat_ok, o_stat_bad
  );
`else
  modport slave (
    input  i_vld, i_x, i_last, i_cfg_compliment, i_res_rdy,
    output o_rdy, o_res_vld, o_res_is_unary, o_res_count, o_res_len
  );
  modport master (
    output i_vld, i_x, i_last, i_cfg_compliment, i_res_rdy,
    input  o_rdy, o_res_vld, o_res_is_unary, o_res_count, o_res_len
  );
`endif
endinterface

// File: rtl/c_unary_stream_chk_beat.sv
// Per-beat edge finder (combinational): edge count saturating at 2, position of first edge, last bit.
module c_unary_beat #(
  parameter int P_W   = 8,
  parameter int POS_W = $clog2(P_W) + 1
) (
  input  logic [P_W-1:0]   x,
  input  logic             prev,
  input  logic             is_first,
  input  logic             mode,
  output logic [1:0]       edges,
  output logic [POS_W-1:0] pos,
  output logic             last_bit
);

  logic             ref_bit;
  logic [P_W-1:0]   diff;

  // On the first beat the reference is the lead value, so a wrong-polarity bit 0 shows up as an edge at 0.
  assign ref_bit  = is_first ? ~mode : prev;
  assign diff     = x ^ {x[P_W-2:0], ref_bit};
  assign last_bit = x[P_W-1];

  always_comb begin
    edges = 2'd0;
    pos   = '0;
    for (int i = P_W - 1; i >= 0; i--) begin
      if (diff[i]) begin
        pos = POS_W'(i);
        if (edges != 2'd2) edges = edges + 2'd1;
      end
    end
  end

endmodule

// File: rtl/c_unary_stream_chk.sv
// Streaming unary checker; result registered one cycle after the last beat, single-entry result reg
// with o_rdy = ~o_res_vld | i_res_rdy. Optional counters via C_UNARY_STREAM_STATS_EN.
module c_unary_stream_chk
  import c_pkg::*;
#(
  parameter int P_W     = 8,
  parameter int P_CNT_W = C_CNT_W
) (
  input logic                  i_clk,
  input logic                  i_rst,
  c_unary_stream_chk_if.slave  bus
);

  localparam int POS_W = $clog2(P_W) + 1;
  localparam logic [P_CNT_W:0] BEAT_INC = (P_CNT_W + 1)'(P_W);

  c_unary_state_t     state_q, state_d;
  logic               mode_q, mode_eff, lead, is_first;
  logic               prev_q, last_bit;
  logic [1:0]         edges;
  logic [POS_W-1:0]   pos;
  logic [P_CNT_W-1:0] cnt_q, cnt_d, cnt_base, len_q, len_d, len_base;
  logic [P_CNT_W:0]   len_sum;
  logic               sat_q, sat_d;
  logic               accept;
  c_unary_result_t    res_q, res_d;
  logic               res_vld_q;

  assign bus.o_rdy  = ~res_vld_q | bus.i_res_rdy;
  assign accept     = bus.i_vld & bus.o_rdy;
  assign is_first   = (state_q == S_FIRST);
  assign mode_eff   = is_first ? bus.i_cfg_compliment : mode_q;
  assign lead       = ~mode_eff;

  c_unary_beat #(.P_W(P_W), .POS_W(POS_W)) u_beat (
    .x        (bus.i_x),
    .prev     (prev_q),
    .is_first (is_first),
    .mode     (mode_eff),
    .edges    (edges),
    .pos      (pos),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FIRST, S_LEAD: begin
        if (is_first && (bus.i_x[0] != lead)) state_d = S_BAD;
        else begin
          case (edges)
            2'd0:    state_d = S_LEAD;
            2'd1:    state_d = S_TRAIL;
            default: state_d = S_BAD;
          endcase
        end
      end
      S_TRAIL: if (edges != 2'd0) state_d = S_BAD;
      default: state_d = S_BAD;
    endcase
  end

  always_comb begin
    cnt_base = is_first ? '0 : cnt_q;
    len_base = is_first ? '0 : len_q;
    cnt_d    = cnt_q;
    if (is_first || state_q == S_LEAD) begin
      if (state_d == S_LEAD)       cnt_d = cnt_base + BEAT_INC[P_CNT_W-1:0];
      else if (state_d == S_TRAIL) cnt_d = cnt_base + {{(P_CNT_W-POS_W){1'b0}}, pos};
    end
    // Sticky saturation: once the length hits the ceiling the code can never be reported as valid.
    len_sum = {1'b0, len_base} + BEAT_INC;
    sat_d   = (~is_first & sat_q) | len_sum[P_CNT_W];
    len_d   = sat_d ? C_LEN_MAX : len_sum[P_CNT_W-1:0];

    res_d.is_unary = (state_d == S_TRAIL) & ~sat_d;
    res_d.count    = res_d.is_unary ? cnt_d : '0;
    res_d.len      = len_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_FIRST;
      mode_q    <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      sat_q     <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      if (accept) begin
        state_q <= bus.i_last ? S_FIRST : state_d;
        mode_q  <= mode_eff;
        prev_q  <= last_bit;
        cnt_q   <= cnt_d;
        len_q   <= len_d;
        sat_q   <= sat_d;
      end
      if (accept && bus.i_last) begin
        res_vld_q <= 1'b1;
        res_q     <= res_d;
      end else if (bus.i_res_rdy) begin
        res_vld_q <= 1'b0;
      end
    end
  end

  assign bus.o_res_vld      = res_vld_q;
  assign bus.o_res_is_unary = res_q.is_unary;
  assign bus.o_res_count    = res_q.count;
  assign bus.o_res_len      = res_q.len;

`ifdef C_UNARY_STREAM_STATS_EN
  logic [31:0] stat_ok_q, stat_bad_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stat_ok_q  <= '0;
      stat_bad_q <= '0;
    end else if (res_vld_q && bus.i_res_rdy) begin
      if (res_q.is_unary) stat_ok_q  <= stat_ok_q + 32'd1;
      else                stat_bad_q <= stat_bad_q + 32'd1;
    end
  end

  assign bus.o_stat_ok  = stat_ok_q;
  assign bus.o_stat_bad = stat_bad_q;
`endif

endmodule
